// File: rtl/stream_parity_gen.sv
// stream_parity_gen: appends a masked word parity bit to each data word on a
// valid/ready stream and reports the parity of each whole frame on its last
// word.
// Optional macro STREAM_PARITY_CNT_EN adds a saturating per-frame word
// counter, which is reported on out_words.
module stream_parity_gen #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              odd,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_en,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_data,
    output logic              out_last,
    output logic              frame_par
`ifdef STREAM_PARITY_CNT_EN
    ,
    output logic [CNT_W-1:0]  out_words
`endif
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] IN_FRAME = 1'b1;

    // A nonsensical width leaves an empty marker block so the illegal
    // configuration is visible in the elaborated hierarchy.
    if (DATA_W < 1 || DATA_W > 64 || CNT_W < 1) begin : g_illegal_width
        logic illegal_width_marker;
    end

    // XOR of the data bits that the mask keeps. The parity sense is applied
    // separately.
    function automatic logic masked_xor(input logic [DATA_W-1:0] d,
                                        input logic [DATA_W-1:0] m);
        return ^(d & m);
    endfunction

    logic [0:0]      state_q, state_d;
    logic            acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [DATA_W:0] out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            fpar_q, fpar_d;
    logic            accept;
    logic            word_x;
    logic            acc_next;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign word_x    = masked_xor(in_data, in_en);
    // The IDLE state means that no frame is open. A new frame therefore
    // starts from a clean accumulator.
    assign acc_next  = ((state_q == IDLE) ? 1'b0 : acc_q) ^ word_x;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_par = fpar_q && out_valid_q && out_last_q;

    // Next-state logic for the output register, the accumulator and the frame FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        fpar_d      = fpar_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = {word_x ^ odd, in_data};
            out_last_d  = in_last;
            fpar_d      = in_last ? (acc_next ^ odd) : 1'b0;
            acc_d       = in_last ? 1'b0 : acc_next;
            state_d     = in_last ? IDLE : IN_FRAME;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register, accumulator and frame state. Reset clears all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            fpar_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            fpar_q      <= fpar_d;
        end
    end

`ifdef STREAM_PARITY_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign out_words = words_q;

    // Saturating count of words in the open frame. The total is reported on the last word only.
    always_comb begin
        cnt_d   = cnt_q;
        words_d = words_q;
        if (accept) begin
            if (in_last) begin
                words_d = cnt_inc;
                cnt_d   = '0;
            end else begin
                words_d = '0;
                cnt_d   = cnt_inc;
            end
        end
    end

    // Counter and out_words register. Reset discards a partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end
`endif

endmodule

// File: tb/tb_stream_parity_gen.sv
// Self-checking bench for stream_parity_gen (DATA_W=8). A queue-based model
// predicts every registered output word from the parity rules.
module tb_stream_parity_gen;

    logic       clk = 1'b0;
    logic       rst, odd, in_valid, in_last, out_ready;
    logic [7:0] in_data, in_en;
    wire        in_ready, out_valid, out_last, frame_par;
    wire  [8:0] out_data;
`ifdef STREAM_PARITY_CNT_EN
    wire [15:0] out_words;
    wire        s_in_ready, s_out_valid, s_out_last, s_frame_par;
    wire  [8:0] s_out_data;
    wire  [1:0] s_out_words;
`endif

    stream_parity_gen #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .odd(odd), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_en(in_en), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_par(frame_par)
`ifdef STREAM_PARITY_CNT_EN
        , .out_words(out_words)
`endif
    );

`ifdef STREAM_PARITY_CNT_EN
    // Narrow-counter copy: used to check that the frame count saturates.
    stream_parity_gen #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .odd(odd), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_en(in_en), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_last(s_out_last),
        .frame_par(s_frame_par), .out_words(s_out_words)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        bit         last;
        bit         fp;
        int         n;
    } exp_t;

    exp_t q[$];
    int   m_par;     // parity of all enabled bits seen so far in the open frame
    int   m_n;       // words seen so far in the open frame
    int   checks = 0;
    int   passed = 0;

    // Advance one clock. The model is updated from the inputs that are present at the edge.
    task automatic tick();
        bit   mready, acc_ok, hs;
        int   wx;
        exp_t e;
        mready = (q.size() == 0) || out_ready;
        acc_ok = in_valid && mready;
        hs     = (q.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_par = 0;
            m_n   = 0;
        end else begin
            if (hs) void'(q.pop_front());
            if (acc_ok) begin
                wx     = $countones(in_data & in_en) % 2;
                e.data = {(wx == 1) ^ odd, in_data};
                e.last = in_last;
                m_par  = (m_par + wx) % 2;
                m_n    = m_n + 1;
                if (in_last) begin
                    e.fp  = (m_par == 1) ^ odd;
                    e.n   = m_n;
                    m_par = 0;
                    m_n   = 0;
                end else begin
                    e.fp = 1'b0;
                    e.n  = 0;
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] en, input logic o,
                        input logic last);
        in_valid = 1'b1; in_data = d; in_en = en; odd = o; in_last = last;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_en = 8'hFF; odd = 1'b0;
        in_last = 1'b0; out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
        checks++; if (out_data !== 9'h000) $display("FAIL rst_data: got %h want 000", out_data); else passed++;
        checks++; if (out_last !== 1'b0 || frame_par !== 1'b0)
            $display("FAIL rst_last_fpar: got %b%b want 00", out_last, frame_par); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else passed++;
`ifdef STREAM_PARITY_CNT_EN
        checks++; if (out_words !== 16'd0) $display("FAIL rst_words: got %0d want 0", out_words); else passed++;
`endif
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_vectors();
        out_ready = 1'b1;
        send(8'hB5, 8'hFF, 1'b0, 1'b1);
        checks++; if (out_data !== 9'h1B5) $display("FAIL b5_data: got %h want 1b5", out_data); else passed++;
        checks++; if (frame_par !== 1'b1 || out_last !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL b5_fpar: got v%b l%b f%b want 111", out_valid, out_last, frame_par); else passed++;
        send(8'hF0, 8'h0F, 1'b1, 1'b1);
        checks++; if (out_data !== 9'h1F0) $display("FAIL masked_odd: got %h want 1f0", out_data); else passed++;
        send(8'h01, 8'hFF, 1'b0, 1'b0);
        checks++; if (out_data !== 9'h101 || frame_par !== 1'b0)
            $display("FAIL frm_w1: got %h f%b want 101 f0", out_data, frame_par); else passed++;
        send(8'h03, 8'hFF, 1'b0, 1'b0);
        checks++; if (out_data !== 9'h003) $display("FAIL frm_w2: got %h want 003", out_data); else passed++;
        send(8'h07, 8'hFF, 1'b0, 1'b1);
        checks++; if (out_data !== 9'h107 || out_last !== 1'b1)
            $display("FAIL frm_w3: got %h l%b want 107 l1", out_data, out_last); else passed++;
        checks++; if (frame_par !== 1'b0) $display("FAIL frm_fpar: got %b want 0", frame_par); else passed++;
`ifdef STREAM_PARITY_CNT_EN
        checks++; if (out_words !== 16'd3) $display("FAIL frm_words: got %0d want 3", out_words); else passed++;
`endif
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(8'h3C, 8'hFF, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 8'h15; in_last = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_data !== 9'h03C || out_valid !== 1'b1)
                $display("FAIL stall_hold%0d: got %h v%b want 03c v1", i, out_data, out_valid); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready%0d: got %b want 0", i, in_ready); else passed++;
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_data !== 9'h115 || frame_par !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL stall_release: got %h f%b v%b want 115 f1 v1", out_data, frame_par, out_valid); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0 || frame_par !== 1'b0)
            $display("FAIL stall_drain: got v%b f%b want v0 f0", out_valid, frame_par); else passed++;
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b1;
        send(8'h01, 8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midrst_state: got v%b r%b want v0 r1", out_valid, in_ready); else passed++;
        rst = 1'b0;
        send(8'h01, 8'hFF, 1'b0, 1'b1);
        checks++; if (frame_par !== 1'b1 || out_data !== 9'h101)
            $display("FAIL midrst_fpar: got %h f%b want 101 f1", out_data, frame_par); else passed++;
`ifdef STREAM_PARITY_CNT_EN
        checks++; if (out_words !== 16'd1) $display("FAIL midrst_words: got %0d want 1", out_words); else passed++;
`endif
        tick();
    endtask

    task automatic test_random();
        exp_t e;
        bit   exp_ready;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            in_en     = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            odd       = ($urandom_range(0, 7) == 0) ? ~odd : odd;
            in_last   = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            #1;
            exp_ready = (q.size() == 0) || out_ready;
            checks++; if (in_ready !== exp_ready)
                $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_ready); else passed++;
            tick();
            checks++; if (out_valid !== (q.size() != 0))
                $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, q.size() != 0); else passed++;
            if (q.size() != 0) begin
                e = q[0];
                checks++; if (out_data !== e.data || out_last !== e.last || frame_par !== (e.last && e.fp))
                    $display("FAIL rnd_word[%0d]: got %h l%b f%b want %h l%b f%b", i, out_data, out_last,
                             frame_par, e.data, e.last, e.last && e.fp); else passed++;
`ifdef STREAM_PARITY_CNT_EN
                checks++; if (out_words !== 16'((e.n > 65535) ? 65535 : e.n) ||
                              s_out_words !== 2'((e.n > 3) ? 3 : e.n))
                    $display("FAIL rnd_words[%0d]: got %0d/%0d want %0d", i, out_words, s_out_words, e.n); else passed++;
`endif
            end else begin
                checks++; if (frame_par !== 1'b0) $display("FAIL rnd_fpar_idle[%0d]: got %b want 0", i, frame_par); else passed++;
            end
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
    endtask

`ifdef STREAM_PARITY_CNT_EN
    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'(i + 1), 8'hFF, 1'b0, i == 4);
        checks++; if (s_out_words !== 2'd3) $display("FAIL sat_words: got %0d want 3", s_out_words); else passed++;
        checks++; if (out_words !== 16'd5) $display("FAIL wide_words: got %0d want 5", out_words); else passed++;
        tick();
    endtask
`endif

    initial begin
        m_par = 0;
        m_n   = 0;
        test_reset();
        test_vectors();
        test_stall();
        test_reset_midframe();
`ifdef STREAM_PARITY_CNT_EN
        test_saturate();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stream_parity_gen.md
STREAM_PARITY_GEN -- requirements
Module: stream_parity_gen

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (legal range 1..64).
REQ-002 Parameter CNT_W, default 16, width of the frame word counter (used only with STREAM_PARITY_CNT_EN).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 odd  input  1  parity sense: 0 = even, 1 = odd; quasi-static, sampled with each accepted word.
REQ-006 in_valid  input  1  upstream word valid.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  DATA_W  data word.
REQ-009 in_en  input  DATA_W  per-bit parity enable mask; bit i = 0 excludes in_data[i] from all parity terms.
REQ-010 in_last  input  1  word closes the current frame.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_data  output  DATA_W+1  {word parity, data}; data bits unmodified.
REQ-014 out_last  output  1  registered copy of in_last.
REQ-015 frame_par  output  1  frame parity; meaningful only when out_valid and out_last, else driven 0.
REQ-016 out_words  output  CNT_W  words in the closing frame (STREAM_PARITY_CNT_EN only).

Function
REQ-017 Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no input-to-ready path other than out_ready).
REQ-018 Word parity = XOR over i of (in_data[i] & in_en[i]), XOR odd.
REQ-019 Latency: an accepted word appears on out_* in the next cycle; one output register stage, full throughput at 1 word/cycle when out_ready = 1.
REQ-020 While out_valid && !out_ready, out_data, out_last, frame_par, out_words hold stable; no word dropped or duplicated.
REQ-021 Output handshake and new accept in the same cycle: register reloads with the new word, out_valid stays 1.
REQ-022 Output handshake with no accept: out_valid clears next cycle.
REQ-023 Frame accumulator acc (1 bit): on each accept, acc_next = acc XOR masked-XOR of the word; on accept with in_last, frame_par = acc_next XOR odd is registered and acc clears to 0.
REQ-024 Single-word frame (in_last on the first word): frame_par equals that word's parity.
REQ-025 State machine: IDLE (acc = 0, no frame open) -> IN_FRAME on accept without in_last; IN_FRAME -> IDLE on accept with in_last; IDLE -> IDLE on accept with in_last.
REQ-026 in_en and odd changes apply only to words accepted after the change.

Reset
REQ-027 With rst = 1 at a clock edge: out_valid = 0, out_data = 0, out_last = 0, frame_par = 0, acc = 0, out_words = 0, state = IDLE.
REQ-028 Reset mid-frame discards the partial frame; the next accepted word starts a new frame.
REQ-029 in_ready is 1 during and after reset (out_valid = 0).

Configuration
REQ-030 Macro STREAM_PARITY_CNT_EN defined: a CNT_W-bit counter increments on each accept, saturates at 2^CNT_W-1, and clears after the accept with in_last; out_words registers (count+1, saturated) alongside out_last and is 0 on non-last words.
REQ-031 Macro STREAM_PARITY_CNT_EN undefined: no counter logic and no out_words port; all other behaviour is identical.

Verification (DATA_W=8)
REQ-032 in_data=0xB5, in_en=0xFF, odd=0, in_last=1 -> next cycle out_data=0x1B5, frame_par=1.
REQ-033 in_data=0xF0, in_en=0x0F, odd=1 -> out_data=0x1F0 (masked bits zero, odd sense).
REQ-034 Frame 0x01, 0x03, 0x07 (last on 3rd), in_en=0xFF, odd=0 -> word parities 1, 0, 1; frame_par=0 on the 3rd; out_words=3 with macro.
REQ-035 out_ready=0 for 2 cycles after a word is registered -> out_data held, in_ready=0, next word delivered after release, no loss.
REQ-036 Accept 0x01 (no last), assert rst 1 cycle, then 0x01 with last -> frame_par=1 (not 0), out_valid=0 during reset.
REQ-037 CNT_W=2 with macro: 5-word frame -> out_words=3 (saturated).
